pulse_train_gen: RTL
====================

Name: pulse_train_gen

Overview:
- Generates a timed train of N rectangular pulses on one output: HIGH for H clocks, then LOW for L clocks, per pulse.
- Drive-side counterpart of the position block's clock-count measurement. It emits timed pulses, such as sensor trigger pulses or stepper/motor drive pulses, that the measuring counters time on the way back.
- Sits between the navigation controller (start/abort handshake) and the physical pulse pin.

Parameters:
- CNT_W, 32, width of the high/low duration inputs and their internal down-counter.
- NUM_W, 16, width of the pulse-count input and the pulses_sent output.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a pulse train; accepted only when busy=0.
- abort  input  1  terminate the train immediately; has priority over everything except reset.
- high_cycles  input  CNT_W  HIGH-phase length in clocks; 0 is treated as 1.
- low_cycles  input  CNT_W  LOW-phase length in clocks; 0 is treated as 1.
- num_pulses  input  NUM_W  number of pulses to emit.
- pulse_out  output  1  generated pulse waveform, registered.
- busy  output  1  a train is in progress (state HIGH or LOW).
- done  output  1  one-cycle strobe after normal completion of a train.
- pulses_sent  output  NUM_W  completed HIGH phases in the current or most recent train.

Behaviour:
- Reset, while rst_n=0, asynchronous: state=IDLE, pulse_out=0, busy=0, done=0, pulses_sent=0, internal counters=0.
- FSM states: IDLE, HIGH, LOW, DONE. All outputs are registered.
- Acceptance: start=1 at a clock edge while in IDLE or DONE (busy=0) latches high_cycles, low_cycles and num_pulses, and clears pulses_sent. Inputs that change later during the train are ignored.
- start while busy=1: ignored, with no effect on the train.
- num_pulses=0 at acceptance: no pulse is emitted. Next state is DONE, so done=1 for one cycle. busy stays 0.
- Otherwise, on the acceptance edge: state goes to HIGH, pulse_out=1 and busy=1. There is zero idle cycles of latency; pulse_out is high in cycle 1, counting the cycle after the accepting edge as cycle 1.
- HIGH: pulse_out=1 for exactly max(H,1) cycles. Then pulses_sent increments and the state goes to LOW.
- LOW: pulse_out=0 for exactly max(L,1) cycles. Then:
  - if pulses_sent==N, go to DONE;
  - otherwise go to HIGH for the next pulse.
- The LOW phase of the final pulse is always emitted, so the train period is uniform.
- DONE: lasts exactly one cycle with done=1 and busy=0, then IDLE. start is accepted in DONE exactly as in IDLE (back-to-back trains).
- abort=1 in HIGH or LOW: next edge goes to IDLE with pulse_out=0 and busy=0. done is not asserted. pulses_sent holds its count.
- abort in IDLE or DONE: no effect, except that a DONE cycle still lasts one cycle. If abort and start are high together, abort wins and start is dropped.
- Arithmetic: the phase counter is an unsigned CNT_W down-counter loaded with max(value,1)-1. pulses_sent never wraps, because it cannot exceed N.
- Reset mid-train: pulse_out drops to 0 immediately (asynchronous). No done strobe.

Optional Feature:
- Macro: PULSE_TRAIN_GEN_REPEAT_EN.
- Defined:
  - num_pulses=0 at acceptance means continuous mode. Pulses repeat indefinitely with busy=1 until abort, and done is never asserted in this mode.
  - pulses_sent saturates at all-ones instead of wrapping.
- Not defined: num_pulses=0 gives the immediate-done behaviour above. No saturation logic is built.

Test Plan:
- Reset then idle: rst_n low mid-HIGH with H=10 -> pulse_out=0 asynchronously. All outputs are 0 after release and stay 0 with start=0.
- Basic train: H=3, L=2, N=2, start at edge 0 ->
  - pulse_out=1 in cycles 1-3 and 6-8, 0 in cycles 4-5 and 9-10;
  - done=1 only in cycle 11, with busy=0 in cycle 11;
  - pulses_sent=2.
- Zero durations: H=0, L=0, N=3 -> alternating 1,0,1,0,1,0 in cycles 1-6, then done in cycle 7.
- Zero pulses (macro undefined): N=0 -> done in cycle 1, pulse_out and busy stay 0.
- Abort and ignored start: H=5, L=5, N=4, start -> start re-asserted in cycle 2 has no effect. abort in cycle 7 -> pulse_out=0 and busy=0 from cycle 8, no done, pulses_sent=1.
- Back-to-back and continuous (macro defined):
  - start held high during the DONE cycle -> new train with pulse_out=1 in the next cycle;
  - N=0, H=1, L=1 -> toggles for 100 cycles with busy=1;
  - abort -> IDLE with no done.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Pulse-train generator: N pulses of H clocks high then L clocks low, with start/abort handshake.
// Optional macro PULSE_TRAIN_GEN_REPEAT_EN: num_pulses=0 runs continuously and pulses_sent saturates.
module pulse_train_gen #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned NUM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulses_sent
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [CNT_W-1:0] hi_ld_q, hi_ld_nxt;
    logic [CNT_W-1:0] lo_ld_q, lo_ld_nxt;
    logic [NUM_W-1:0] num_q, num_nxt;
    logic [NUM_W-1:0] sent_nxt;
    logic             pulse_nxt, busy_nxt, done_nxt;
    logic             cont_q, cont_nxt;

    logic [CNT_W-1:0] hi_in_ld_c, lo_in_ld_c;
    logic [NUM_W-1:0] sent_inc_c;
    logic             zero_done_c;
    logic             last_pulse_c;

    // Phase counters load max(value,1)-1 so a zero duration still lasts one clock
    assign hi_in_ld_c = (high_cycles == '0) ? '0 : high_cycles - CNT_W'(1);
    assign lo_in_ld_c = (low_cycles  == '0) ? '0 : low_cycles  - CNT_W'(1);

`ifdef PULSE_TRAIN_GEN_REPEAT_EN
    assign sent_inc_c   = (&pulses_sent) ? pulses_sent : pulses_sent + NUM_W'(1);
    assign zero_done_c  = 1'b0;
    assign last_pulse_c = !cont_q && (pulses_sent == num_q);
`else
    assign sent_inc_c   = pulses_sent + NUM_W'(1);
    assign zero_done_c  = 1'b1;
    assign last_pulse_c = (pulses_sent == num_q);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_ld_q     <= '0;
            lo_ld_q     <= '0;
            num_q       <= '0;
            cont_q      <= 1'b0;
            pulses_sent <= '0;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            hi_ld_q     <= hi_ld_nxt;
            lo_ld_q     <= lo_ld_nxt;
            num_q       <= num_nxt;
            cont_q      <= cont_nxt;
            pulses_sent <= sent_nxt;
            pulse_out   <= pulse_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    // Next state plus next values of all registered outputs
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        hi_ld_nxt = hi_ld_q;
        lo_ld_nxt = lo_ld_q;
        num_nxt   = num_q;
        cont_nxt  = cont_q;
        sent_nxt  = pulses_sent;
        pulse_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (start && !abort) begin
                    hi_ld_nxt = hi_in_ld_c;
                    lo_ld_nxt = lo_in_ld_c;
                    num_nxt   = num_pulses;
                    sent_nxt  = '0;
                    cont_nxt  = (num_pulses == '0);
                    if ((num_pulses == '0) && zero_done_c) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_HIGH;
                        cnt_nxt   = hi_in_ld_c;
                        pulse_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                    end
                end
            end

            ST_HIGH: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_nxt = ST_LOW;
                    sent_nxt  = sent_inc_c;
                    cnt_nxt   = lo_ld_q;
                    busy_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt_q - CNT_W'(1);
                    pulse_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end

            ST_LOW: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_q == '0) begin
                    if (last_pulse_c) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_HIGH;
                        cnt_nxt   = hi_ld_q;
                        pulse_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt  = cnt_q - CNT_W'(1);
                    busy_nxt = 1'b1;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
